max14866_ctrl: RTL and testbench

Serial load controller for one or more daisy-chained MAX14866 16-channel HV analog switches on the probe front end.
- Accepts a parallel switch-pattern word through a valid/ready handshake.
- Shifts the word out MSB-first on a divided serial clock, then pulses the active-low latch enable.
- Checks the word shifted back out on the chain's DOUT against the previously loaded pattern.
- Sits between the acquisition sequencer (which chooses the active transducer elements) and the mux pins.

---
 rtl/max14866_ctrl.sv | 143 ++++++++++++++
 tb/tb_max14866_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/max14866_ctrl.sv
// Serial loader for daisy-chained MAX14866 HV switches. It shifts a pattern out MSB-first,
// pulses the active-low latch, and checks the chain readback against the previous pattern.
module max14866_ctrl #(
  parameter int unsigned SWITCH_N = 16,
  parameter int unsigned CHAIN_N  = 1,
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned LE_W     = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [SWITCH_N*CHAIN_N-1:0] cfg_data,
  output logic                        busy,
  output logic                        done,
  output logic                        rb_err,
  input  logic                        rb_clr,
  output logic                        mux_clk,
  output logic                        mux_din,
  output logic                        mux_le_n,
  input  logic                        mux_dout
);

  localparam int unsigned TOTAL   = SWITCH_N * CHAIN_N;
  localparam int unsigned CNT_W   = $clog2(TOTAL + 1);
  localparam int unsigned DIV_MAX = (CLK_DIV > LE_W) ? CLK_DIV : LE_W;
  localparam int unsigned DIV_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_LATCH} state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TOTAL-1:0]   sr_q, sr_d;
  logic [TOTAL-1:0]   pat_q, pat_d;
  logic [TOTAL-1:0]   shadow_q, shadow_d;
  logic               din_q, din_d;
  logic               done_q, done_d;
  logic               rb_err_q, rb_err_d;
  logic               rb_sample, rb_exp, clk_last, le_last;

  assign clk_last = (div_q == DIV_W'(CLK_DIV - 1));
  assign le_last  = (div_q == DIV_W'(LE_W - 1));

  // After rising edge k the counter holds TOTAL-k, so it directly indexes the expected shadow bit.
  always_comb begin
    rb_exp = 1'b0;
    for (int unsigned i = 0; i < TOTAL; i++) begin
      if (cnt_q == CNT_W'(i)) rb_exp = shadow_q[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    pat_d     = pat_q;
    shadow_d  = shadow_q;
    done_d    = 1'b0;
    rb_sample = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          state_d = S_LOW;
          div_d   = '0;
          cnt_d   = CNT_W'(TOTAL);
          sr_d    = cfg_data;
          pat_d   = cfg_data;
        end
      end
      S_LOW: begin
        rb_sample = (div_q == '0) && (cnt_q != CNT_W'(TOTAL));
        if (clk_last) begin
          div_d   = '0;
          state_d = S_HIGH;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_HIGH: begin
        if (clk_last) begin
          div_d   = '0;
          sr_d    = sr_q << 1;
          cnt_d   = cnt_q - CNT_W'(1);
          state_d = (cnt_q == CNT_W'(1)) ? S_LATCH : S_LOW;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_LATCH: begin
        rb_sample = (div_q == '0);
        if (le_last) begin
          div_d    = '0;
          state_d  = S_IDLE;
          shadow_d = pat_q;
          done_d   = 1'b1;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    din_d = (state_d == S_LOW) ? sr_d[TOTAL-1] : din_q;
    // A new mismatch takes priority over a simultaneous clear.
    if (rb_sample && (mux_dout != rb_exp)) rb_err_d = 1'b1;
    else if (rb_clr)                       rb_err_d = 1'b0;
    else                                   rb_err_d = rb_err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      cnt_q    <= '0;
      sr_q     <= '0;
      pat_q    <= '0;
      shadow_q <= '0;
      din_q    <= 1'b0;
      done_q   <= 1'b0;
      rb_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      pat_q    <= pat_d;
      shadow_q <= shadow_d;
      din_q    <= din_d;
      done_q   <= done_d;
      rb_err_q <= rb_err_d;
    end
  end

  assign cfg_ready = (state_q == S_IDLE);
  assign busy      = ~cfg_ready;
  assign done      = done_q;
  assign rb_err    = rb_err_q;
  assign mux_clk   = (state_q == S_HIGH);
  assign mux_le_n  = (state_q != S_LATCH);
  assign mux_din   = din_q;

endmodule

// File: tb/tb_max14866_ctrl.sv
// Bench for max14866_ctrl: three parameter sets, each with a MAX14866 chain model
// and a cycle-timeline reference of the expected pin activity.
module tb_max14866_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_chk = 0, n_pass = 0, n_fin = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int unsigned CH  = (g == 1) ? 2 : 1;
    localparam int unsigned CD  = (g == 2) ? 1 : 2;
    localparam int unsigned LW  = (g == 2) ? 1 : 2;
    localparam int unsigned T   = 16 * CH;
    localparam int unsigned LAT = 2 * CD * T + LW + 1;
    localparam int unsigned LAT_LIT  = (g == 0) ? 67 : (g == 1) ? 131 : 34;
    localparam int unsigned EDGE_LIT = (g == 1) ? 32 : 16;
    localparam logic [31:0] P1 = (g == 1) ? 32'hDEADBEEF : 32'h0000A5C3;

    logic         rst = 1'b0, cfg_valid = 1'b0, rb_clr = 1'b0, mux_dout = 1'b0;
    logic         cfg_ready, busy, done, rb_err, mux_clk, mux_din, mux_le_n;
    logic [T-1:0] cfg_data = '0;

    max14866_ctrl #(.SWITCH_N(16), .CHAIN_N(CH), .CLK_DIV(CD), .LE_W(LW)) dut (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_data(cfg_data), .busy(busy), .done(done), .rb_err(rb_err), .rb_clr(rb_clr),
      .mux_clk(mux_clk), .mux_din(mux_din), .mux_le_n(mux_le_n), .mux_dout(mux_dout)
    );

    // Chain model: DOUT presents the bit about to leave, the chain captures DIN, LE rise latches.
    logic [T-1:0] chain = '0, sw = '0;
    int unsigned  edge_cnt = 0, mis_cnt = 0, le_cnt = 0, flip_k = 0;
    // Reference timeline of the controller.
    int unsigned  ph = 0, edge_base = 0, mis_base = 0;
    logic [T-1:0] pat_m = '0, shadow_m = '0;
    logic         done_m = 1'b0, din_last = 1'b0, exp_rb = 1'b0;

    always @(posedge mux_clk) begin : dev_shift
      int unsigned k;
      logic d;
      edge_cnt++;
      k = edge_cnt - edge_base;
      d = chain[T-1] ^ (k == flip_k);
      if (k >= 1 && k <= T && d !== shadow_m[T-k]) mis_cnt++;
      chain = {chain[T-2:0], mux_din};
      mux_dout = d;
    end

    always @(posedge mux_le_n) begin
      sw = chain;
      le_cnt++;
    end

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        ph = 0; shadow_m = '0; done_m = 1'b0; din_last = 1'b0; exp_rb = 1'b0;
      end else begin
        done_m = 1'b0;
        if (ph != 0) begin
          ph++;
          if (ph == LAT) begin
            ph = 0; done_m = 1'b1; shadow_m = pat_m; din_last = pat_m[0];
            if (mis_cnt != mis_base) exp_rb = 1'b1;
          end
        end else begin
          if (rb_clr) exp_rb = 1'b0;
          if (cfg_valid) begin
            ph = 1; pat_m = cfg_data; edge_base = edge_cnt; mis_base = mis_cnt;
          end
        end
      end
    end

    always @(negedge clk) begin : cmp
      logic [5:0] e;
      int unsigned n, b, w;
      if (ph == 0) e = {1'b1, 1'b0, done_m, 1'b0, din_last, 1'b1};
      else begin
        n = ph - 1;
        if (n < 2 * CD * T) begin
          b = n / (2 * CD);
          w = n % (2 * CD);
          e = {1'b0, 1'b1, 1'b0, (w >= CD), pat_m[T-1-b], 1'b1};
        end else e = {1'b0, 1'b1, 1'b0, 1'b0, pat_m[0], 1'b0};
      end
      check($sformatf("g%0d_pins", g), {cfg_ready, busy, done, mux_clk, mux_din, mux_le_n}, e);
      if (ph == 0) check($sformatf("g%0d_rb_err", g), rb_err, exp_rb);
      if (done_m) check($sformatf("g%0d_switch", g), sw, pat_m);
    end

    task automatic send(input logic [T-1:0] d, output int unsigned base);
      int unsigned t = 0;
      cfg_valid = 1'b1;
      cfg_data  = d;
      while (!cfg_ready && t < LAT + 50) begin @(negedge clk); t++; end
      check($sformatf("g%0d_accept_ready", g), cfg_ready, 1'b1);
      @(posedge clk);
      base = edge_cnt;
      @(negedge clk);
      cfg_valid = 1'b0;
    endtask

    task automatic wait_done(output int unsigned lat);
      lat = 1;
      while (!done && lat < LAT + 50) begin @(negedge clk); lat++; end
    endtask

    initial begin : stim
      int unsigned base, lat, le0, gap, acc, t;
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      check($sformatf("g%0d_reset", g),
            {cfg_ready, busy, done, mux_clk, mux_din, mux_le_n, rb_err}, 7'b1000010);
      rst = 1'b0;
      @(negedge clk);

      send(P1[T-1:0], base);
      wait_done(lat);
      check($sformatf("g%0d_latency", g), lat, LAT_LIT);
      check($sformatf("g%0d_edges", g), edge_cnt - base, EDGE_LIT);
      check($sformatf("g%0d_sw_first", g), sw, P1[T-1:0]);
      check($sformatf("g%0d_rb_first", g), rb_err, 1'b0);

      send(T'(32'h1), base);
      wait_done(lat);
      check($sformatf("g%0d_sw_second", g), sw, T'(32'h1));
      check($sformatf("g%0d_rb_second", g), rb_err, 1'b0);

      flip_k = 5;
      send(T'(32'h1234), base);
      wait_done(lat);
      flip_k = 0;
      check($sformatf("g%0d_rb_flip", g), rb_err, 1'b1);
      @(negedge clk);
      check($sformatf("g%0d_rb_sticky", g), rb_err, 1'b1);
      rb_clr = 1'b1;
      @(negedge clk);
      rb_clr = 1'b0;
      check($sformatf("g%0d_rb_clr", g), rb_err, 1'b0);

      le0 = le_cnt;
      send(T'(32'hFFFF_FFFF), base);
      t = 0;
      while (edge_cnt - base < 7 && t < LAT) begin @(negedge clk); t++; end
      #2 rst = 1'b1;
      @(negedge clk);
      check($sformatf("g%0d_abort_pins", g),
            {cfg_ready, busy, done, mux_clk, mux_din, mux_le_n, rb_err}, 7'b1000010);
      check($sformatf("g%0d_abort_le", g), le_cnt - le0, 0);
      check($sformatf("g%0d_abort_sw", g), sw, T'(32'h1234));
      rst = 1'b0;
      @(negedge clk);
      send(T'(32'h0F0F_0F0F), base);
      wait_done(lat);
      check($sformatf("g%0d_lat_after_abort", g), lat, LAT_LIT);
      rb_clr = 1'b1;
      @(negedge clk);
      rb_clr = 1'b0;

      cfg_valid = 1'b1;
      acc = 0; gap = 0; t = 0;
      while (acc < 4 && t < 5 * (LAT + 10)) begin
        cfg_data = T'({$urandom, $urandom});
        @(negedge clk);
        t++;
        if (!cfg_ready) gap++;
        else begin
          if (gap != 0) begin
            check($sformatf("g%0d_ready_gap", g), gap, LAT_LIT - 1);
            acc++;
          end
          gap = 0;
        end
      end
      cfg_valid = 1'b0;
      check($sformatf("g%0d_gap_count", g), acc, 4);

      for (int i = 0; i < 6; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        if ($urandom_range(0, 2) == 0) begin
          rb_clr = 1'b1;
          @(negedge clk);
          rb_clr = 1'b0;
        end
        flip_k = ($urandom_range(0, 3) == 0) ? $urandom_range(1, T) : 0;
        send(T'({$urandom, $urandom}), base);
        wait_done(lat);
        flip_k = 0;
        check($sformatf("g%0d_lat_rand", g), lat, LAT_LIT);
      end
      n_fin++;
    end
  end

  initial begin : top_ctl
    int unsigned t = 0;
    while (n_fin < 3 && t < 40000) begin @(posedge clk); t++; end
    check("all_sequences_finished", n_fin, 3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
